// File: rtl/uart_rx_ingress.sv
// 8N1 UART receiver with a 2-entry output FIFO and valid/ready handoff.
// Framing errors and overruns are reported as single-cycle pulses.
`timescale 1ns/1ps
module uart_rx_ingress #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] FULL = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] ONE  = BW'(1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  logic          s1;
  logic          rs;
  logic [2:0]    state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic [7:0]    mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    cnt;

  logic          tick;
  logic          push;
  logic          bad_stop;
  logic          pop;
  logic          full;
  logic          do_push;
  logic          drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      rs <= 1'b1;
    end else begin
      s1 <= rx;
      rs <= s1;
    end
  end

  assign tick     = (baud == '0);
  assign push     = ena && state == STOP && tick && rs;
  assign bad_stop = ena && state == STOP && tick && !rs;
  assign pop      = out_valid && out_ready;
  assign full     = (cnt == 2'(FIFO_DEPTH));
  assign do_push  = push && (!full || pop);
  assign drop     = push && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else if (!ena) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rs) begin
            state <= START;
            baud  <= HALF;
          end
        end
        START: begin
          if (!tick) begin
            baud <= baud - ONE;
          end else if (!rs) begin
            state   <= DATA;
            baud    <= FULL;
            bit_idx <= '0;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (!tick) begin
            baud <= baud - ONE;
          end else begin
            shift <= {rs, shift[7:1]};
            baud  <= FULL;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (!tick) begin
            baud <= baud - ONE;
          end else begin
            state <= rs ? IDLE : WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          // a held-low line (break) must not look like a new start bit
          if (rs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case (1'b1)
        do_push && !pop: cnt <= cnt + 2'd1;
        !do_push && pop: cnt <= cnt - 2'd1;
        default:         cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      overrun   <= drop;
    end
  end

  assign out_data  = mem[rd_ptr];
  assign out_valid = (cnt != 2'd0);

endmodule

// File: tb/tb_uart_rx_ingress.sv
// Scenario bench for uart_rx_ingress: scoreboard of expected bytes
// popped by a monitor, plus per-scenario pulse and handshake checks.
`timescale 1ns/1ps
module tb_uart_rx_ingress;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       rx;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int failures = 0;
  int valid_cycles = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  logic [7:0] sb [$];

  uart_rx_ingress #(.CLKS_PER_BIT(16), .FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .rx        (rx),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) valid_cycles++;
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL pop_unexpected got=%h required=none",
                   out_data);
        end else begin
          logic [7:0] exp;
          exp = sb.pop_front();
          if (out_data !== exp) begin
            failures++;
            $display("FAIL pop_data got=%h required=%h",
                     out_data, exp);
          end
        end
      end
    end
  end

  task automatic send_bit(input logic v);
    @(posedge clk);
    #1 rx = v;
    repeat (15) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    if (!stop) send_bit(1'b1);
  endtask

  task automatic wait_empty(output bit ok);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    ok = (sb.size() == 0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_valid got=%b required=0", out_valid);
    end
    checks++;
    if (out_data !== 8'h00) begin
      failures++;
      $display("FAIL rst_data got=%h required=00", out_data);
    end
    checks++;
    if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL rst_pulses got=%b%b required=00",
               frame_err, overrun);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_single;
    int v0, f0, o0;
    bit ok;
    out_ready = 1'b1;
    v0 = valid_cycles; f0 = fe_cnt; o0 = ov_cnt;
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_empty(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL single_drain got=%0d required=0", sb.size());
    end
    checks++;
    if (valid_cycles - v0 != 1) begin
      failures++;
      $display("FAIL single_valid_cycles got=%0d required=1",
               valid_cycles - v0);
    end
    checks++;
    if (fe_cnt != f0 || ov_cnt != o0) begin
      failures++;
      $display("FAIL single_pulses got=%0d/%0d required=0/0",
               fe_cnt - f0, ov_cnt - o0);
    end
  endtask

  task automatic test_glitch;
    int v0;
    bit ok;
    v0 = valid_cycles;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx = 1'b1;
    repeat (60) @(posedge clk);
    checks++;
    if (valid_cycles != v0) begin
      failures++;
      $display("FAIL glitch_push got=%0d required=0",
               valid_cycles - v0);
    end
    sb.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_empty(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL glitch_next got=%0d required=0", sb.size());
    end
  endtask

  task automatic test_frame_err;
    int v0, f0, o0;
    bit ok;
    v0 = valid_cycles; f0 = fe_cnt; o0 = ov_cnt;
    send_frame(8'h81, 1'b0);
    repeat (4) @(posedge clk);
    checks++;
    if (fe_cnt - f0 != 1) begin
      failures++;
      $display("FAIL ferr_count got=%0d required=1", fe_cnt - f0);
    end
    checks++;
    if (valid_cycles != v0 || ov_cnt != o0) begin
      failures++;
      $display("FAIL ferr_push got=%0d/%0d required=0/0",
               valid_cycles - v0, ov_cnt - o0);
    end
    sb.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    wait_empty(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL ferr_next got=%0d required=0", sb.size());
    end
  endtask

  task automatic test_overrun;
    int o0;
    bit ok;
    out_ready = 1'b0;
    o0 = ov_cnt;
    sb.push_back(8'h11);
    sb.push_back(8'h22);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h11) begin
      failures++;
      $display("FAIL ovr_head got=%b/%h required=1/11",
               out_valid, out_data);
    end
    checks++;
    if (ov_cnt - o0 != 1) begin
      failures++;
      $display("FAIL ovr_count got=%0d required=1", ov_cnt - o0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_empty(ok);
    @(negedge clk);
    checks++;
    if (!ok || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovr_drain got=%0d/%b required=0/0",
               sb.size(), out_valid);
    end
  endtask

  task automatic test_push_pop_full;
    int o0;
    bit ok;
    out_ready = 1'b0;
    o0 = ov_cnt;
    sb.push_back(8'h11);
    sb.push_back(8'h22);
    sb.push_back(8'h33);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    fork
      send_frame(8'h33, 1'b1);
      begin
        // stop-bit sample edge is 155 edges after start bit drive
        repeat (155) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_empty(ok);
    @(negedge clk);
    checks++;
    if (ov_cnt != o0) begin
      failures++;
      $display("FAIL pp_overrun got=%0d required=0", ov_cnt - o0);
    end
    checks++;
    if (!ok || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL pp_drain got=%0d/%b required=0/0",
               sb.size(), out_valid);
    end
  endtask

  task automatic test_ena;
    int v0, f0;
    bit ok;
    out_ready = 1'b1;
    v0 = valid_cycles; f0 = fe_cnt;
    fork
      send_frame(8'h99, 1'b1);
      begin
        repeat (40) @(posedge clk);
        #1 ena = 1'b0;
      end
    join
    repeat (4) @(posedge clk);
    checks++;
    if (valid_cycles != v0 || fe_cnt != f0) begin
      failures++;
      $display("FAIL ena_discard got=%0d/%0d required=0/0",
               valid_cycles - v0, fe_cnt - f0);
    end
    #1 ena = 1'b1;
    sb.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    wait_empty(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL ena_next got=%0d required=0", sb.size());
    end
  endtask

  task automatic test_reset_midframe;
    bit ok;
    out_ready = 1'b0;
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
      failures++;
      $display("FAIL mid_prefill got=%b/%h required=1/5a",
               out_valid, out_data);
    end
    fork
      send_frame(8'h99, 1'b1);
      begin
        repeat (89) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
          failures++;
          $display("FAIL mid_reset got=%b/%h required=0/00",
                   out_valid, out_data);
        end
        checks++;
        if (frame_err !== 1'b0 || overrun !== 1'b0) begin
          failures++;
          $display("FAIL mid_pulses got=%b%b required=00",
                   frame_err, overrun);
        end
        sb.delete();
      end
    join
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (160) @(posedge clk);
    sb.push_back(8'hF0);
    send_frame(8'hF0, 1'b1);
    wait_empty(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL mid_next got=%0d required=0", sb.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ena = 1'b1;
    rx = 1'b1;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_push_pop_full();
    test_ena();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
